div_iter: RTL
=============

# div_iter

Multi-cycle radix-2 restoring divider serving DIV.W / MOD.W / DIV.WU / MOD.WU for the execution stage. It replaces single-cycle `/` and `%` operators with a 32-iteration shift-subtract engine and returns quotient and remainder together. The execution stage acts as initiator: it raises `start_i`, stalls the pipeline while `ready_o` is low, and consumes the result on `done_o`. The pipeline flush path cancels the divider through `flush_i`.

## Interface
- Parameters:
  - `WIDTH`, 32: operand and result width. Only 32 is required to work.
- Ports:
  - `clk`, in, 1: clock. All state updates on the rising edge.
  - `rst`, in, 1: reset, asynchronous, active-high.
  - `start_i`, in, 1: request. Accepted only in a cycle where `ready_o`=1.
  - `signed_i`, in, 1: 1 selects signed (DIV.W/MOD.W), 0 selects unsigned (.WU). Sampled with `start_i`.
  - `dividend_i`, in, WIDTH: dividend. Sampled with `start_i`.
  - `divisor_i`, in, WIDTH: divisor. Sampled with `start_i`.
  - `flush_i`, in, 1: cancel the operation in flight.
  - `ready_o`, out, 1: idle, can accept a request.
  - `done_o`, out, 1: one-cycle pulse; results are valid in this cycle.
  - `quotient_o`, out, WIDTH: quotient.
  - `remainder_o`, out, WIDTH: remainder.

## Operation
- States:
  - IDLE: `ready_o`=1.
  - CALC: 32 iterations.
  - DONE: `done_o`=1.
- Transitions:
  - IDLE to CALC when `start_i` is high and `flush_i` is low. On that edge the block latches |dividend|, |divisor|, the quotient sign (dividend sign XOR divisor sign, signed mode only), the remainder sign (dividend sign, signed mode only), and clears the 6-bit iteration counter.
  - IDLE to DONE directly when the accepted divisor is 0.
  - CALC to DONE on the edge where counter = 31.
  - DONE to IDLE unconditionally.
  - Any state to IDLE when `flush_i`=1. Flush has priority over start, iteration, and completion. `done_o` is not raised for a flushed operation, and the output registers are not updated.
- Iteration step, using a 33-bit partial remainder P and quotient shift register Q:
  - Form {P,Q} shifted left by 1.
  - Trial T = P[31:0] − divisor.
  - If T is non-negative, P = T and Q[0] = 1; otherwise Q[0] = 0.
- On entry to DONE, `quotient_o` and `remainder_o` are loaded with the sign-corrected results:
  - Quotient is negated if its sign bit is set.
  - Remainder is negated if its sign bit is set.
  - The remainder therefore takes the sign of the dividend.
- Special cases, decided behaviour:
  - Divide by zero, any mode: quotient = 0xFFFF_FFFF, remainder = dividend.
  - Signed 0x8000_0000 / 0xFFFF_FFFF: quotient = 0x8000_0000, remainder = 0. The normal datapath produces this by wrap-around; no special logic is needed, but the case must be verified.
  - Unsigned mode never negates.
- `quotient_o` and `remainder_o` hold their values until the next completed operation.
- `start_i` while `ready_o`=0 is ignored. No queueing.

## Timing
- Reset values:
  - state = IDLE
  - `ready_o`=1
  - `done_o`=0
  - `quotient_o`=0
  - `remainder_o`=0
  - counter = 0
- Asserting `rst` mid-operation aborts immediately and asynchronously.
- Normal latency:
  - Start is accepted in cycle 0.
  - CALC occupies cycles 1–32.
  - `done_o`=1 and results are valid in cycle 33.
  - `ready_o` returns to 1 in cycle 34.
- Divide-by-zero latency: start in cycle 0, `done_o` in cycle 1, `ready_o` in cycle 2.
- Flush is asserted in cycle n and the block is IDLE in cycle n+1. A new start is accepted in cycle n+1.
- Throughput: one operation per 34 cycles, or per 2 cycles for divide-by-zero.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Structure
- Add to the shared `defines.v`:
  - `` `DivStart `` / `` `DivStop ``, request encodings.
  - `` `DivResultReady `` / `` `DivResultNotReady ``, done encodings.
  - The existing `` `RegBus `` for WIDTH.
- State encoding and counter width stay local to the module.
- One natural sub-module, `div_step`: a combinational single iteration. Inputs P, Q, divisor; outputs next P, next Q.
- Absolute value and sign correction stay inline.

## Test plan
- Unsigned 100 / 7: start in cycle 0 → `done_o` in cycle 33, q=14, r=2. `ready_o` is low in cycles 1–33.
- Signed −7 / 2 (0xFFFF_FFF9, 0x2) → q=0xFFFF_FFFD (−3), r=0xFFFF_FFFF (−1). Same operands unsigned → q=0x7FFF_FFFC, r=1.
- Signed 0x8000_0000 / 0xFFFF_FFFF → q=0x8000_0000, r=0.
- Divisor 0 with dividend 0x1234 (each mode): `done_o` in cycle 1, q=0xFFFF_FFFF, r=0x1234.
- Cancellation:
  - `flush_i` in cycle 10 of a 100/7 op → no `done_o`; `ready_o`=1 in cycle 11; outputs keep their prior values.
  - A new start 50/5 issued in cycle 11 → q=10, r=0 in cycle 44.
  - `start_i` asserted together with `flush_i` in IDLE → ignored.
- Reset and back-to-back:
  - `rst` pulsed in cycle 5 of an op → all outputs at reset values immediately.
  - Back-to-back requests: start held high → second op accepted in cycle 34; `start_i` in cycles 1–33 has no effect.

Source files
------------

// File: rtl/div_iter_pkg.sv
// Shared types and encodings for the iterative divider.
package div_iter_pkg;

  localparam int REG_BUS = 32;

  localparam logic DIV_START             = 1'b1;
  localparam logic DIV_STOP              = 1'b0;
  localparam logic DIV_RESULT_READY      = 1'b1;
  localparam logic DIV_RESULT_NOT_READY  = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_iter_step.sv
// One restoring shift-subtract iteration; purely combinational.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   p_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   p_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0]   p_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH+1:0] trial;

  always_comb begin
    p_sh  = {p_i[WIDTH-1:0], q_i[WIDTH-1]};
    q_sh  = {q_i[WIDTH-2:0], 1'b0};
    // One extra guard bit so the borrow is visible even when p_sh uses bit WIDTH.
    trial = {1'b0, p_sh} - {2'b00, divisor_i};
    if (!trial[WIDTH+1]) begin
      p_o = trial[WIDTH:0];
      q_o = q_sh | {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      p_o = p_sh;
      q_o = q_sh;
    end
  end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider for DIV.W/MOD.W/DIV.WU/MOD.WU.
//
// state  | meaning
// S_IDLE | ready_o=1, waiting for start_i
// S_CALC | 32 shift-subtract iterations
// S_DONE | done_o=1, results valid
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = REG_BUS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

  div_state_e       state;
  logic [5:0]       cnt;
  logic [WIDTH:0]   p_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] dvsr_q;
  logic             q_neg;
  logic             r_neg;

  logic [WIDTH:0]   p_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_i      (p_q),
    .q_i      (q_q),
    .divisor_i(dvsr_q),
    .p_o      (p_nxt),
    .q_o      (q_nxt)
  );

  always_comb begin
    a_neg = signed_i & dividend_i[WIDTH-1];
    b_neg = signed_i & divisor_i[WIDTH-1];
    a_abs = a_neg ? (~dividend_i + WIDTH'(1)) : dividend_i;
    b_abs = b_neg ? (~divisor_i + WIDTH'(1)) : divisor_i;
    // Sign correction applied to the final iteration output so results land on the DONE edge.
    q_fin = q_neg ? (~q_nxt + WIDTH'(1)) : q_nxt;
    r_fin = r_neg ? (~p_nxt[WIDTH-1:0] + WIDTH'(1)) : p_nxt[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      p_q         <= '0;
      q_q         <= '0;
      dvsr_q      <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      ready_o     <= 1'b1;
      done_o      <= DIV_RESULT_NOT_READY;
      quotient_o  <= '0;
      remainder_o <= '0;
    end else if (flush_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ready_o <= 1'b1;
      done_o  <= DIV_RESULT_NOT_READY;
    end else begin
      case (state)
        S_IDLE: begin
          done_o <= DIV_RESULT_NOT_READY;
          if (start_i == DIV_START) begin
            ready_o <= 1'b0;
            cnt     <= '0;
            p_q     <= '0;
            q_q     <= a_abs;
            dvsr_q  <= b_abs;
            q_neg   <= a_neg ^ b_neg;
            r_neg   <= a_neg;
            if (divisor_i == '0) begin
              state       <= S_DONE;
              done_o      <= DIV_RESULT_READY;
              quotient_o  <= '1;
              remainder_o <= dividend_i;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          p_q <= p_nxt;
          q_q <= q_nxt;
          cnt <= cnt + 6'd1;
          if (cnt == CNT_LAST) begin
            state       <= S_DONE;
            done_o      <= DIV_RESULT_READY;
            quotient_o  <= q_fin;
            remainder_o <= r_fin;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          done_o  <= DIV_RESULT_NOT_READY;
          ready_o <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          done_o  <= DIV_RESULT_NOT_READY;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule
